// File: rtl/csa_acc_pkg.sv
// Shared types, parameter checks and derivations for csa_accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } acc_state_e;

  localparam int unsigned MIN_ACC_WIDTH = 2;
  localparam int unsigned MIN_CHUNK     = 1;

  function automatic int unsigned calc_nchunk(input int unsigned acc_width,
                                              input int unsigned chunk);
    return acc_width / chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned acc_width,
                                   input int unsigned chunk,
                                   input int unsigned count_width);
    return (width >= 1) && (acc_width >= width) && (acc_width >= MIN_ACC_WIDTH) &&
           (chunk >= MIN_CHUNK) && (chunk <= acc_width) &&
           ((acc_width % chunk) == 0) && (count_width >= 1);
  endfunction

endpackage

// File: rtl/csa_accumulator_full_adder.sv
// One-bit full adder; a 3:2 compressor cell and ripple-adder cell in one.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator with a chunked carry-propagate resolve.
// Define CSA_ACC_OVF_EN to add the sticky out_ovf port and its tracking logic.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned CHUNK       = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic [COUNT_WIDTH-1:0] out_count
`ifdef CSA_ACC_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int unsigned NCHUNK = calc_nchunk(ACC_WIDTH, CHUNK);
  localparam int unsigned CIDX_W = idx_width(NCHUNK);

  if (!params_ok(WIDTH, ACC_WIDTH, CHUNK, COUNT_WIDTH)) begin : g_bad_params
    $error("csa_accumulator: invalid WIDTH/ACC_WIDTH/CHUNK/COUNT_WIDTH combination");
  end

  acc_state_e state_q, state_d;

  logic [ACC_WIDTH-1:0]   s_q, s_d;
  logic [ACC_WIDTH-1:0]   c_q, c_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CIDX_W-1:0]      chunk_q, chunk_d;
  logic                   cin_q, cin_d;

  logic                   accept;
  logic                   handshake;
  logic                   last_chunk;
  logic [ACC_WIDTH-1:0]   opnd;
  logic [ACC_WIDTH-1:0]   csa_s;
  logic [ACC_WIDTH-1:0]   csa_maj;
  logic [CHUNK-1:0]       rs_a;
  logic [CHUNK-1:0]       rs_b;
  logic [CHUNK-1:0]       rs_sum;
  logic [CHUNK:0]         rs_carry;

  assign opnd       = ACC_WIDTH'(in_data);
  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign last_chunk = (chunk_q == CIDX_W'(NCHUNK - 1));

  // 3:2 compressor row: S, C and the new operand fold into a fresh S/C pair.
  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_csa
    full_adder u_fa (
      .a  (s_q[i]),
      .b  (c_q[i]),
      .ci (opnd[i]),
      .s  (csa_s[i]),
      .co (csa_maj[i])
    );
  end

  assign rs_a        = s_q[chunk_q*CHUNK +: CHUNK];
  assign rs_b        = c_q[chunk_q*CHUNK +: CHUNK];
  assign rs_carry[0] = cin_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_resolve
    full_adder u_fa (
      .a  (rs_a[i]),
      .b  (rs_b[i]),
      .ci (rs_carry[i]),
      .s  (rs_sum[i]),
      .co (rs_carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = in_last ? RESOLVE : ACCUM;
        ACCUM:   if (accept && in_last) state_d = RESOLVE;
        RESOLVE: if (last_chunk) state_d = DONE;
        DONE:    if (handshake) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    out_valid = (state_q == DONE);
    out_sum   = s_q;
    out_count = cnt_q;
  end

  always_comb begin
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    chunk_d = chunk_q;
    cin_d   = cin_q;
    if (clear) begin
      s_d     = '0;
      c_d     = '0;
      cnt_d   = '0;
      chunk_d = '0;
      cin_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            s_d     = opnd;
            c_d     = '0;
            cnt_d   = COUNT_WIDTH'(1);
            chunk_d = '0;
            cin_d   = 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_d   = csa_s;
            c_d   = {csa_maj[ACC_WIDTH-2:0], 1'b0};
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end
        end
        RESOLVE: begin
          s_d[chunk_q*CHUNK +: CHUNK] = rs_sum;
          cin_d   = rs_carry[CHUNK];
          chunk_d = last_chunk ? '0 : chunk_q + 1'b1;
        end
        DONE: begin
          if (handshake) begin
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            chunk_d = '0;
            cin_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      chunk_q <= '0;
      cin_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      chunk_q <= chunk_d;
      cin_q   <= cin_d;
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q, ovf_d;

  // Weight lost off the top of the carry row, or out of the final chunk, is overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) ovf_d = 1'b0;
        ACCUM:   if (accept) ovf_d = ovf_q | csa_maj[ACC_WIDTH-1];
        RESOLVE: if (last_chunk) ovf_d = ovf_q | rs_carry[CHUNK];
        DONE:    if (handshake) ovf_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  logic unused_maj_msb;
  assign unused_maj_msb = csa_maj[ACC_WIDTH-1];
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomized bench for csa_accumulator against an arithmetic sum model.
module tb_csa_accumulator;

  localparam int unsigned NCH = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
`ifdef CSA_ACC_OVF_EN
  logic        out_ovf;
`endif

  logic        clr8, v8, rdy8, l8, ov8, ordy8;
  logic [7:0]  d8, sum8, cnt8;
`ifdef CSA_ACC_OVF_EN
  logic        ovf8;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CHUNK(4), .COUNT_WIDTH(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  csa_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .CHUNK(4), .COUNT_WIDTH(8)) dut8 (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clr8),
    .in_valid  (v8),
    .in_ready  (rdy8),
    .in_data   (d8),
    .in_last   (l8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_sum   (sum8),
    .out_count (cnt8)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (ovf8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready_on_send", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Waits for the result, holds out_ready low for `hold` cycles, then consumes it.
  task automatic collect(input string tag, input logic [15:0] esum, input logic [7:0] ecnt,
                         input bit eovf, input int hold, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, esum});
    check({tag, "_count"}, {24'd0, out_count}, {24'd0, ecnt});
`ifdef CSA_ACC_OVF_EN
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
`else
    if (eovf) begin end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_sum"}, {16'd0, out_sum}, {16'd0, esum});
      check({tag, "_hold_count"}, {24'd0, out_count}, {24'd0, ecnt});
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic rand_txn(input int n);
    longint sum = 0;
    logic [7:0] d;
    int lat;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      sum += longint'(d);
      send(d, i == n - 1);
    end
    idle_inputs();
    collect("rand", 16'(sum % 65536), 8'((n > 255) ? 255 : n), sum >= 65536,
            int'($urandom_range(0, 3)), lat);
    check("rand_latency", 32'(lat), NCH);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_rst = 1'b0; clear = 1'b0; out_ready = 1'b0;
    idle_inputs();
    clr8 = 1'b0; v8 = 1'b0; l8 = 1'b0; d8 = '0; ordy8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
`ifdef CSA_ACC_OVF_EN
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    n_rst = 1'b1;
    @(negedge clk);

    // three 0xFF operands back-to-back
    send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 1);
    idle_inputs();
    collect("fff", 16'h02FD, 8'd3, 1'b0, 0, lat);
    check("fff_latency", 32'(lat), NCH);

    // single operand: latency and first-cycle in_ready drop
    send(8'h5A, 1);
    idle_inputs();
    check("single_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("single_not_valid_yet", {31'd0, out_valid}, 32'd0);
    collect("single", 16'h005A, 8'd1, 1'b0, 0, lat);
    check("single_latency", 32'(lat), NCH);

    // backpressure held for 6 cycles
    send(8'h5A, 1);
    idle_inputs();
    collect("stall", 16'h005A, 8'd1, 1'b0, 6, lat);

    // clear in the second RESOLVE cycle
    send(8'h11, 0); send(8'h22, 1);
    idle_inputs();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_in_ready", {31'd0, in_ready}, 32'd1);
    check("clear_out_sum", {16'd0, out_sum}, 32'd0);
    check("clear_out_count", {24'd0, out_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("clear_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    send(8'h03, 1);
    idle_inputs();
    collect("after_clear", 16'h0003, 8'd1, 1'b0, 0, lat);

    // clear coinciding with an output handshake
    send(8'h44, 1);
    idle_inputs();
    repeat (NCH) @(negedge clk);
    check("clrhs_valid", {31'd0, out_valid}, 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    check("clrhs_idle", {31'd0, in_ready}, 32'd1);
    check("clrhs_sum_zero", {16'd0, out_sum}, 32'd0);

    // asynchronous reset mid-ACCUM with in_valid held
    send(8'h10, 0); send(8'h20, 0);
    in_valid = 1'b1; in_data = 8'h30; in_last = 1'b0;
    n_rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
    check("midrst_out_count", {24'd0, out_count}, 32'd0);
    @(negedge clk);
    check("midrst_hold_sum", {16'd0, out_sum}, 32'd0);
    idle_inputs();
    n_rst = 1'b1;
    @(negedge clk);
    send(8'h01, 0); send(8'h02, 1);
    idle_inputs();
    collect("post_rst", 16'h0003, 8'd2, 1'b0, 0, lat);

    // narrow instance: 0x80 + 0x80 wraps to zero
    v8 = 1'b1; d8 = 8'h80; l8 = 1'b0;
    @(negedge clk);
    l8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; l8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("w8_valid", {31'd0, ov8}, 32'd1);
    check("w8_latency", 32'(lat), 32'd2);
    check("w8_sum", {24'd0, sum8}, 32'd0);
    check("w8_count", {24'd0, cnt8}, 32'd2);
`ifdef CSA_ACC_OVF_EN
    check("w8_ovf", {31'd0, ovf8}, 32'd1);
`endif
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("w8_post_valid", {31'd0, ov8}, 32'd0);
    check("w8_post_ready", {31'd0, rdy8}, 32'd1);

    // randomized transactions, including one that saturates the count
    for (int t = 0; t < 10; t++) rand_txn(int'($urandom_range(1, 12)));
    rand_txn(300);
    rand_txn(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
